// File: rtl/sweep_scheduler.sv
// Solar tracker scan sequencer: sweeps the horizontal then vertical servo, samples the ADC
// at each position, strobes the capture register on a new maximum, and parks on the best point.
module sweep_scheduler #(
    parameter int unsigned PW_MIN        = 100000,
    parameter int unsigned PW_MAX        = 200000,
    parameter int unsigned PW_STEP       = 10000,
    parameter int unsigned PW_PARK       = 150000,
    parameter int unsigned SETTLE_CYCLES = 2000000,
    parameter int unsigned ADC_TIMEOUT   = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [11:0] ADC_DATA,
    input  logic        ADC_VALID,
    input  logic [11:0] LV,
    input  logic [31:0] pulseWidth_max_H,
    input  logic [31:0] pulseWidth_max_V,
    output logic [31:0] pulseWidth_H,
    output logic [31:0] pulseWidth_V,
    output logic        GT,
    output logic        REG_CLR,
    output logic        ADC_REQ,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > ADC_TIMEOUT) ? SETTLE_CYCLES : ADC_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_MOVE,
        S_SETTLE,
        S_SAMPLE,
        S_COMPARE,
        S_NEXT,
        S_PARK_H,
        S_PARK,
        S_DONE
    } state_t;

    state_t             state;
    logic               phase_v;
    logic               hit;
    logic [CNT_W-1:0]   cnt;

    logic [31:0]        cur_pos;
    logic [32:0]        next_pos;
    logic               step_ok;

    // Next sweep point on the active axis, evaluated in 33 bits so the bound test cannot wrap.
    assign cur_pos  = phase_v ? pulseWidth_V : pulseWidth_H;
    assign next_pos = {1'b0, cur_pos} + 33'(PW_STEP);
    assign step_ok  = (next_pos <= 33'(PW_MAX));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            phase_v      <= 1'b0;
            hit          <= 1'b0;
            cnt          <= '0;
            pulseWidth_H <= 32'(PW_PARK);
            pulseWidth_V <= 32'(PW_PARK);
            GT           <= 1'b0;
            REG_CLR      <= 1'b0;
            ADC_REQ      <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            ERR          <= 1'b0;
        end else begin
            GT      <= 1'b0;
            REG_CLR <= 1'b0;
            ADC_REQ <= 1'b0;
            DONE    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (START) begin
                        ERR     <= 1'b0;
                        REG_CLR <= 1'b1;
                        BUSY    <= 1'b1;
                        state   <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    phase_v      <= 1'b0;
                    hit          <= 1'b0;
                    pulseWidth_H <= 32'(PW_MIN);
                    pulseWidth_V <= 32'(PW_PARK);
                    cnt          <= '0;
                    state        <= S_SETTLE;
                end

                S_SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt     <= '0;
                        ADC_REQ <= 1'b1;
                        state   <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // GT is decided on the accepting edge so it is already valid in COMPARE.
                S_SAMPLE: begin
                    if (ADC_VALID) begin
                        GT    <= (ADC_DATA > LV);
                        state <= S_COMPARE;
                    end else if (cnt == CNT_W'(ADC_TIMEOUT - 1)) begin
                        ERR   <= 1'b1;
                        state <= S_NEXT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_COMPARE: begin
                    if (GT) begin
                        hit <= 1'b1;
                    end
                    state <= S_NEXT;
                end

                S_NEXT: begin
                    if (step_ok) begin
                        if (phase_v) begin
                            pulseWidth_V <= next_pos[31:0];
                        end else begin
                            pulseWidth_H <= next_pos[31:0];
                        end
                        cnt   <= '0;
                        state <= S_SETTLE;
                    end else begin
                        state <= phase_v ? S_PARK : S_PARK_H;
                    end
                end

                S_PARK_H: begin
                    pulseWidth_H <= hit ? pulseWidth_max_H : 32'(PW_PARK);
                    pulseWidth_V <= 32'(PW_MIN);
                    phase_v      <= 1'b1;
                    cnt          <= '0;
                    state        <= S_SETTLE;
                end

                S_PARK: begin
                    pulseWidth_H <= hit ? pulseWidth_max_H : 32'(PW_PARK);
                    pulseWidth_V <= hit ? pulseWidth_max_V : 32'(PW_PARK);
                    DONE         <= 1'b1;
                    state        <= S_DONE;
                end

                S_DONE: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end

                // S_MOVE is never entered: positions are applied on the transition edge itself.
                default: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler with a behavioural capture register and ADC responder.
module tb_sweep_scheduler;

    localparam int unsigned PMIN  = 10;
    localparam int unsigned PSTEP = 10;
    localparam int unsigned PPARK = 30;

    logic        CLK;
    logic        RST;
    logic        START_a, START_b;
    logic [11:0] ADC_DATA;
    logic        ADC_VALID;
    logic [11:0] LV;
    logic [31:0] max_h, max_v;
    logic [31:0] pwh_a, pwv_a, pwh_b, pwv_b;
    logic        gt_a, clr_a, req_a, busy_a, done_a, err_a;
    logic        gt_b, clr_b, req_b, busy_b, done_b, err_b;
    logic        use_b;
    logic [11:0] adc_hold;

    logic [31:0] m_pw_h, m_pw_v;
    logic        m_gt, m_clr, m_req, m_busy, m_done, m_err;

    int total = 0;
    int bad   = 0;

    logic [11:0] samp [0:15];
    bit          withhold [0:15];
    int          base = 0;

    int          n_req = 0, n_gt = 0, n_done = 0, n_overlap = 0, cyc = 0, err_rise = 0;
    logic [31:0] req_h [0:255];
    logic [31:0] req_v [0:255];
    int          req_cyc [0:255];
    logic [31:0] gt_h [0:255];
    logic [31:0] gt_v [0:255];
    logic        prev_err;

    sweep_scheduler #(.PW_MIN(10), .PW_MAX(50), .PW_STEP(10), .PW_PARK(30),
                      .SETTLE_CYCLES(3), .ADC_TIMEOUT(8)) dut_a (
        .CLK(CLK), .RST(RST), .START(START_a), .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID),
        .LV(LV), .pulseWidth_max_H(max_h), .pulseWidth_max_V(max_v),
        .pulseWidth_H(pwh_a), .pulseWidth_V(pwv_a), .GT(gt_a), .REG_CLR(clr_a),
        .ADC_REQ(req_a), .BUSY(busy_a), .DONE(done_a), .ERR(err_a)
    );

    sweep_scheduler #(.PW_MIN(10), .PW_MAX(45), .PW_STEP(10), .PW_PARK(30),
                      .SETTLE_CYCLES(3), .ADC_TIMEOUT(8)) dut_b (
        .CLK(CLK), .RST(RST), .START(START_b), .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID),
        .LV(LV), .pulseWidth_max_H(max_h), .pulseWidth_max_V(max_v),
        .pulseWidth_H(pwh_b), .pulseWidth_V(pwv_b), .GT(gt_b), .REG_CLR(clr_b),
        .ADC_REQ(req_b), .BUSY(busy_b), .DONE(done_b), .ERR(err_b)
    );

    assign m_pw_h = use_b ? pwh_b  : pwh_a;
    assign m_pw_v = use_b ? pwv_b  : pwv_a;
    assign m_gt   = use_b ? gt_b   : gt_a;
    assign m_clr  = use_b ? clr_b  : clr_a;
    assign m_req  = use_b ? req_b  : req_a;
    assign m_busy = use_b ? busy_b : busy_a;
    assign m_done = use_b ? done_b : done_a;
    assign m_err  = use_b ? err_b  : err_a;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Capture register: cleared by RST or REG_CLR, loads the last ADC sample and positions on GT.
    always @(posedge CLK) begin
        if (ADC_VALID) adc_hold <= ADC_DATA;
        if (RST || m_clr) begin
            LV    <= 12'd0;
            max_h <= 32'd0;
            max_v <= 32'd0;
        end else if (m_gt) begin
            LV    <= adc_hold;
            max_h <= m_pw_h;
            max_v <= m_pw_v;
        end
    end

    // ADC responder and event recorder, sampling 2 time units after each rising edge.
    initial begin
        ADC_VALID = 1'b0;
        ADC_DATA  = 12'd0;
        prev_err  = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            cyc++;
            ADC_VALID = 1'b0;
            if (m_req) begin
                int idx;
                idx = n_req - base;
                if (n_req < 256) begin
                    req_h[n_req]   = m_pw_h;
                    req_v[n_req]   = m_pw_v;
                    req_cyc[n_req] = cyc;
                end
                if (idx >= 0 && idx < 16 && !withhold[idx]) begin
                    ADC_VALID = 1'b1;
                    ADC_DATA  = samp[idx];
                end
                n_req++;
            end
            if (m_gt) begin
                if (n_gt < 256) begin
                    gt_h[n_gt] = m_pw_h;
                    gt_v[n_gt] = m_pw_v;
                end
                n_gt++;
            end
            if (m_done) n_done++;
            if (m_gt && m_clr) n_overlap++;
            if (m_err && !prev_err) err_rise = cyc;
            prev_err = m_err;
        end
    end

    task automatic clear_samples();
        for (int i = 0; i < 16; i++) begin
            samp[i]     = 12'd0;
            withhold[i] = 1'b0;
        end
    endtask

    task automatic run_scan(input bit extra_start);
        int  d0;
        bit  seen;
        d0   = n_done;
        base = n_req;
        @(negedge CLK);
        if (use_b) START_b = 1'b1; else START_a = 1'b1;
        @(negedge CLK);
        START_a = 1'b0;
        START_b = 1'b0;
        total++;
        if (m_clr !== 1'b1 || m_busy !== 1'b1 || m_err !== 1'b0 || m_gt !== 1'b0) begin
            bad++;
            $display("FAIL clear_cycle: clr=%b busy=%b err=%b gt=%b, expected 1 1 0 0",
                     m_clr, m_busy, m_err, m_gt);
        end
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge CLK);
            if (extra_start && i == 20) begin
                if (use_b) START_b = 1'b1; else START_a = 1'b1;
            end else begin
                START_a = 1'b0;
                START_b = 1'b0;
            end
            if (m_done) seen = 1'b1;
        end
        START_a = 1'b0;
        START_b = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: DONE not seen within 2000 cycles, expected one pulse");
        end else begin
            total++;
            if (m_busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_in_done: busy=%b expected 1", m_busy);
            end
            @(negedge CLK);
            total++;
            if (m_done !== 1'b0 || m_busy !== 1'b0) begin
                bad++;
                $display("FAIL done_end: done=%b busy=%b expected 0 0", m_done, m_busy);
            end
            total++;
            if (n_done - d0 != 1) begin
                bad++;
                $display("FAIL done_count: got %0d expected 1", n_done - d0);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        total++;
        if (m_pw_h !== 32'd30 || m_pw_v !== 32'd30) begin
            bad++;
            $display("FAIL reset_pw: H=%0d V=%0d expected 30 30", m_pw_h, m_pw_v);
        end
        total++;
        if ({m_gt, m_clr, m_req, m_busy, m_done, m_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {m_gt, m_clr, m_req, m_busy, m_done, m_err});
        end
    endtask

    task automatic test_h_sweep();
        int g0;
        int exp_gt [3] = '{10, 20, 30};
        clear_samples();
        samp[0] = 12'd100; samp[1] = 12'd400; samp[2] = 12'd900;
        samp[3] = 12'd300; samp[4] = 12'd200;
        g0 = n_gt;
        run_scan(1'b0);
        total++;
        if (n_req - base != 10) begin
            bad++;
            $display("FAIL h_req_count: got %0d expected 10", n_req - base);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (req_h[base+k] !== 32'(PMIN + PSTEP*k) || req_v[base+k] !== 32'(PPARK)) begin
                bad++;
                $display("FAIL h_pos%0d: H=%0d V=%0d expected %0d 30", k,
                         req_h[base+k], req_v[base+k], PMIN + PSTEP*k);
            end
            total++;
            if (req_h[base+5+k] !== 32'd30 || req_v[base+5+k] !== 32'(PMIN + PSTEP*k)) begin
                bad++;
                $display("FAIL h_vpos%0d: H=%0d V=%0d expected 30 %0d", k,
                         req_h[base+5+k], req_v[base+5+k], PMIN + PSTEP*k);
            end
        end
        // The first sample also beats the freshly cleared maximum of 0.
        total++;
        if (n_gt - g0 != 3) begin
            bad++;
            $display("FAIL h_gt_count: got %0d expected 3", n_gt - g0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (gt_h[g0+k] !== 32'(exp_gt[k])) begin
                    bad++;
                    $display("FAIL h_gt_pos%0d: got %0d expected %0d", k, gt_h[g0+k], exp_gt[k]);
                end
            end
        end
        total++;
        if (m_pw_h !== 32'd30 || m_pw_v !== 32'd30) begin
            bad++;
            $display("FAIL h_final: H=%0d V=%0d expected 30 30", m_pw_h, m_pw_v);
        end
    endtask

    task automatic test_tie();
        int g0;
        clear_samples();
        samp[6] = 12'd500;
        samp[8] = 12'd500;
        g0 = n_gt;
        run_scan(1'b0);
        total++;
        if (n_gt - g0 != 1) begin
            bad++;
            $display("FAIL tie_gt_count: got %0d expected 1", n_gt - g0);
        end else begin
            total++;
            if (gt_h[g0] !== 32'd30 || gt_v[g0] !== 32'd20) begin
                bad++;
                $display("FAIL tie_gt_pos: H=%0d V=%0d expected 30 20", gt_h[g0], gt_v[g0]);
            end
        end
        total++;
        if (m_pw_h !== 32'd30 || m_pw_v !== 32'd20) begin
            bad++;
            $display("FAIL tie_final: H=%0d V=%0d expected 30 20", m_pw_h, m_pw_v);
        end
    endtask

    task automatic test_timeout();
        int g0;
        int exp_gt [4] = '{10, 20, 30, 50};
        clear_samples();
        samp[0] = 12'd5; samp[1] = 12'd6; samp[2] = 12'd7;
        samp[3] = 12'd999; samp[4] = 12'd8;
        withhold[3] = 1'b1;
        g0 = n_gt;
        run_scan(1'b0);
        total++;
        if (n_req - base != 10) begin
            bad++;
            $display("FAIL tmo_req_count: got %0d expected 10", n_req - base);
        end
        total++;
        if (req_h[base+3] !== 32'd40 || req_h[base+4] !== 32'd50) begin
            bad++;
            $display("FAIL tmo_pos: H3=%0d H4=%0d expected 40 50", req_h[base+3], req_h[base+4]);
        end
        total++;
        if (err_rise - req_cyc[base+3] != 8) begin
            bad++;
            $display("FAIL tmo_err_delay: got %0d expected 8", err_rise - req_cyc[base+3]);
        end
        total++;
        if (n_gt - g0 != 4) begin
            bad++;
            $display("FAIL tmo_gt_count: got %0d expected 4", n_gt - g0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (gt_h[g0+k] !== 32'(exp_gt[k])) begin
                    bad++;
                    $display("FAIL tmo_gt_pos%0d: got %0d expected %0d", k, gt_h[g0+k], exp_gt[k]);
                end
            end
        end
        total++;
        if (m_err !== 1'b1) begin
            bad++;
            $display("FAIL tmo_err_sticky: err=%b expected 1", m_err);
        end
        total++;
        if (m_pw_h !== 32'd50 || m_pw_v !== 32'd30) begin
            bad++;
            $display("FAIL tmo_final: H=%0d V=%0d expected 50 30", m_pw_h, m_pw_v);
        end
    endtask

    task automatic test_all_zero();
        int g0;
        clear_samples();
        g0 = n_gt;
        run_scan(1'b0);
        total++;
        if (n_gt - g0 != 0) begin
            bad++;
            $display("FAIL zero_gt_count: got %0d expected 0", n_gt - g0);
        end
        total++;
        if (m_pw_h !== 32'd30 || m_pw_v !== 32'd30 || m_err !== 1'b0) begin
            bad++;
            $display("FAIL zero_final: H=%0d V=%0d err=%b expected 30 30 0", m_pw_h, m_pw_v, m_err);
        end
    endtask

    task automatic test_non_multiple();
        int d0;
        clear_samples();
        use_b = 1'b1;
        run_scan(1'b1);
        total++;
        if (n_req - base != 8) begin
            bad++;
            $display("FAIL nm_req_count: got %0d expected 8", n_req - base);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (req_h[base+k] !== 32'(PMIN + PSTEP*k) || req_v[base+4+k] !== 32'(PMIN + PSTEP*k)) begin
                bad++;
                $display("FAIL nm_pos%0d: H=%0d V=%0d expected %0d %0d", k,
                         req_h[base+k], req_v[base+4+k], PMIN + PSTEP*k, PMIN + PSTEP*k);
            end
        end
        d0 = n_done;
        repeat (20) @(negedge CLK);
        total++;
        if (m_busy !== 1'b0 || n_done != d0 || m_pw_h !== 32'd30 || m_pw_v !== 32'd30) begin
            bad++;
            $display("FAIL nm_idle_after: busy=%b extra_done=%0d H=%0d V=%0d expected 0 0 30 30",
                     m_busy, n_done - d0, m_pw_h, m_pw_v);
        end
        use_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        int  d0;
        bit  found;
        clear_samples();
        base = n_req;
        @(negedge CLK);
        START_a = 1'b1;
        @(negedge CLK);
        START_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge CLK);
            if (m_pw_v == 32'd20) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rst_reach_v: V=20 not reached within 500 cycles, got V=%0d", m_pw_v);
        end
        d0  = n_done;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        total++;
        if (m_pw_h !== 32'd30 || m_pw_v !== 32'd30) begin
            bad++;
            $display("FAIL rst_mid_pw: H=%0d V=%0d expected 30 30", m_pw_h, m_pw_v);
        end
        total++;
        if ({m_gt, m_clr, m_req, m_busy, m_done, m_err} !== 6'b0) begin
            bad++;
            $display("FAIL rst_mid_strobes: got %b expected 000000",
                     {m_gt, m_clr, m_req, m_busy, m_done, m_err});
        end
        repeat (20) @(negedge CLK);
        total++;
        if (n_done != d0 || m_busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_no_done: extra_done=%0d busy=%b expected 0 0", n_done - d0, m_busy);
        end
    endtask

    initial begin
        RST     = 1'b1;
        START_a = 1'b0;
        START_b = 1'b0;
        use_b   = 1'b0;
        clear_samples();
        repeat (3) @(posedge CLK);
        test_reset();
        RST = 1'b0;
        test_h_sweep();
        test_tie();
        test_timeout();
        test_all_zero();
        test_non_multiple();
        test_reset_mid();
        total++;
        if (n_overlap != 0) begin
            bad++;
            $display("FAIL gt_clr_overlap: got %0d cycles expected 0", n_overlap);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
